// File: rtl/proc_core_p.sv
// ---------------------------------------------------------------------------
// proc_core_p -- tiny accumulator processor.
//
// One instruction byte per fetch: opcode = IR[7:4], operand = IR[3:0].
// Single accumulator AC, address register AR, NREG general registers,
// zero and carry flags. Loads and stores go through a simple strobe/ready
// data port.
//
// Ports
//   clock       in   rising-edge clock for all state
//   reset_n     in   synchronous active-low reset
//   enable      in   run permission, looked at in IDLE and at the end of
//                    every instruction
//   iram_addr   out  instruction address (the PC)
//   iram_data   in   instruction byte
//   iram_valid  in   iram_data is valid this cycle
//   dram_addr   out  data address (AR)
//   dram_wdata  out  store data (AC)
//   dram_rd_en  out  read strobe, only in MEM
//   dram_wr_en  out  write strobe, only in MEM
//   dram_rdata  in   read data
//   dram_ready  in   access complete (ignored outside MEM)
//   finish      out  core has halted
//   zflag       out  zero flag
//   cflag       out  carry / borrow flag
//   dbg_state   out  current FSM state (0 IDLE, 1 FETCH, 2 EXEC, 3 MEM, 4 HALT)
//
// Data port handshake: in MEM the strobe is raised and AR/AC are held
// steady; the access completes on the first rising edge where dram_ready
// is 1, and the strobe is low from the following cycle on.
// ---------------------------------------------------------------------------
module proc_core_p #(
    parameter int DATA_W  = 16,
    parameter int DADDR_W = 16,
    parameter int IADDR_W = 8,
    parameter int NREG    = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               enable,
    output logic [IADDR_W-1:0] iram_addr,
    input  logic [7:0]         iram_data,
    input  logic               iram_valid,
    output logic [DADDR_W-1:0] dram_addr,
    output logic [DATA_W-1:0]  dram_wdata,
    output logic               dram_rd_en,
    output logic               dram_wr_en,
    input  logic [DATA_W-1:0]  dram_rdata,
    input  logic               dram_ready,
    output logic               finish,
    output logic               zflag,
    output logic               cflag,
    output logic [2:0]         dbg_state
);

    // Register index is IR[1:0] reduced mod NREG; NREG is 2 or 4, so the
    // reduction is just keeping the low index bits.
    localparam int RIDX_W = (NREG > 2) ? 2 : 1;

    localparam logic [3:0] OP_LDI   = 4'h1;
    localparam logic [3:0] OP_ST    = 4'h2;
    localparam logic [3:0] OP_LD    = 4'h3;
    localparam logic [3:0] OP_ADD   = 4'h4;
    localparam logic [3:0] OP_SUB   = 4'h5;
    localparam logic [3:0] OP_INC   = 4'h6;
    localparam logic [3:0] OP_SETA  = 4'h7;
    localparam logic [3:0] OP_LOAD  = 4'h8;
    localparam logic [3:0] OP_STORE = 4'h9;
    localparam logic [3:0] OP_JZ    = 4'hA;
    localparam logic [3:0] OP_JMP   = 4'hB;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [IADDR_W-1:0]  r_pc;
    logic [7:0]          r_ir;
    logic [DATA_W-1:0]   r_ac;
    logic [DADDR_W-1:0]  r_ar;
    logic [DATA_W-1:0]   r_regs [NREG];
    logic                r_z;
    logic                r_c;

    logic [3:0]          w_op;
    logic [RIDX_W-1:0]   w_idx;
    logic [DATA_W-1:0]   w_rn;
    logic [DATA_W:0]     w_sum;
    logic [DATA_W:0]     w_diff;
    logic                w_rd;
    logic                w_wr;

    assign w_op  = r_ir[7:4];
    assign w_idx = r_ir[RIDX_W-1:0];
    assign w_rn  = r_regs[w_idx];

    // One extra bit on top: carry-out for ADD, borrow for SUB.
    assign w_sum  = {1'b0, r_ac} + {1'b0, w_rn};
    assign w_diff = {1'b0, r_ac} - {1'b0, w_rn};

    // -----------------------------------------------------------------
    // FSM next state and strobes
    // -----------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        w_rd   = 1'b0;
        w_wr   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) w_next = S_FETCH;
            end
            S_FETCH: begin
                if (iram_valid) w_next = S_EXEC;
            end
            S_EXEC: begin
                if (w_op == OP_LOAD || w_op == OP_STORE) begin
                    w_next = S_MEM;
                end else if (w_op == OP_HALT) begin
                    w_next = S_HALT;
                end else begin
                    w_next = enable ? S_FETCH : S_IDLE;
                end
            end
            S_MEM: begin
                // IR only holds LOAD or STORE here, so exactly one strobe.
                w_rd = (w_op == OP_LOAD);
                w_wr = (w_op == OP_STORE);
                if (dram_ready) w_next = enable ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // -----------------------------------------------------------------
    // Datapath
    // -----------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_pc <= '0;
            r_ir <= '0;
            r_ac <= '0;
            r_ar <= '0;
            r_z  <= 1'b0;
            r_c  <= 1'b0;
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (iram_valid) begin
                        r_ir <= iram_data;
                        r_pc <= r_pc + IADDR_W'(1);
                    end
                end
                S_EXEC: begin
                    case (w_op)
                        OP_LDI: begin
                            r_ac <= DATA_W'(r_ir[3:0]);
                            r_z  <= (r_ir[3:0] == 4'd0);
                        end
                        OP_ST:   r_regs[w_idx] <= r_ac;
                        OP_LD: begin
                            r_ac <= w_rn;
                            r_z  <= (w_rn == '0);
                        end
                        OP_ADD: begin
                            r_ac <= w_sum[DATA_W-1:0];
                            r_c  <= w_sum[DATA_W];
                            r_z  <= (w_sum[DATA_W-1:0] == '0);
                        end
                        OP_SUB: begin
                            r_ac <= w_diff[DATA_W-1:0];
                            r_c  <= w_diff[DATA_W];
                            r_z  <= (w_diff[DATA_W-1:0] == '0);
                        end
                        OP_INC:  r_regs[w_idx] <= w_rn + DATA_W'(1);
                        OP_SETA: r_ar <= DADDR_W'(w_rn);
                        // JZ tests the flag as it stood before this
                        // instruction; the jump replaces the fetch increment.
                        OP_JZ:   if (r_z) r_pc <= IADDR_W'(w_rn);
                        OP_JMP:  r_pc <= IADDR_W'(w_rn);
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (dram_ready && w_op == OP_LOAD) begin
                        r_ac <= dram_rdata;
                        r_z  <= (dram_rdata == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign iram_addr  = r_pc;
    assign dram_addr  = r_ar;
    assign dram_wdata = r_ac;
    assign dram_rd_en = w_rd;
    assign dram_wr_en = w_wr;
    assign finish     = (r_state == S_HALT);
    assign zflag      = r_z;
    assign cflag      = r_c;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_proc_core_p.sv
// ---------------------------------------------------------------------------
// tb_proc_core_p -- directed programs for proc_core_p.
//
// A 16-bit core is checked every cycle against an instruction-level model
// (one instruction per accepted fetch). An 8-bit core runs the same
// programs alongside and is pinned with literal end-of-program values.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_proc_core_p;

    // -----------------------------------------------------------------
    // Clock / reset
    // -----------------------------------------------------------------
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n;
    logic        enable;
    logic        iram_valid;

    // 16-bit core
    logic [7:0]  iram_addr;
    logic [7:0]  iram_data;
    logic [15:0] dram_addr;
    logic [15:0] dram_wdata;
    logic [15:0] dram_rdata;
    logic        dram_rd_en;
    logic        dram_wr_en;
    logic        dram_ready;
    logic        finish;
    logic        zflag;
    logic        cflag;
    logic [2:0]  dbg_state;

    // 8-bit core
    logic [7:0]  iram_addr8;
    logic [7:0]  iram_data8;
    logic [15:0] dram_addr8;
    logic [7:0]  dram_wdata8;
    logic [7:0]  dram_rdata8;
    logic        dram_rd_en8;
    logic        dram_wr_en8;
    logic        dram_ready8;
    logic        finish8;
    logic        zflag8;
    logic        cflag8;
    logic [2:0]  dbg_state8;

    logic [7:0]  prog [256];
    logic [15:0] dmem [16] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000,
                               16'h0000, 16'h0000, 16'h1234, 16'h0000,
                               16'h0000, 16'hBEEF, 16'h0000, 16'h0000,
                               16'h0000, 16'h0000, 16'h0000, 16'h0000};
    logic [7:0]  dmem8 [16] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h34, 8'h00,
                                8'h00, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    proc_core_p u_dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .iram_addr  (iram_addr),
        .iram_data  (iram_data),
        .iram_valid (iram_valid),
        .dram_addr  (dram_addr),
        .dram_wdata (dram_wdata),
        .dram_rd_en (dram_rd_en),
        .dram_wr_en (dram_wr_en),
        .dram_rdata (dram_rdata),
        .dram_ready (dram_ready),
        .finish     (finish),
        .zflag      (zflag),
        .cflag      (cflag),
        .dbg_state  (dbg_state)
    );

    proc_core_p #(.DATA_W(8)) u_dut8 (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .iram_addr  (iram_addr8),
        .iram_data  (iram_data8),
        .iram_valid (iram_valid),
        .dram_addr  (dram_addr8),
        .dram_wdata (dram_wdata8),
        .dram_rd_en (dram_rd_en8),
        .dram_wr_en (dram_wr_en8),
        .dram_rdata (dram_rdata8),
        .dram_ready (dram_ready8),
        .finish     (finish8),
        .zflag      (zflag8),
        .cflag      (cflag8),
        .dbg_state  (dbg_state8)
    );

    assign iram_data  = prog[iram_addr];
    assign iram_data8 = prog[iram_addr8];

    // -----------------------------------------------------------------
    // Data memory responders: ready after ready_delay strobe cycles;
    // with spur set, ready is also driven high whenever no access is open.
    // -----------------------------------------------------------------
    int ready_delay = 0;
    bit spur = 1'b0;
    int rcnt = 0;
    int rcnt8 = 0;

    assign dram_rdata  = dmem[dram_addr[3:0]];
    assign dram_rdata8 = dmem8[dram_addr8[3:0]];
    assign dram_ready  = ((dram_rd_en || dram_wr_en) && rcnt >= ready_delay) ||
                         (spur && !(dram_rd_en || dram_wr_en));
    assign dram_ready8 = ((dram_rd_en8 || dram_wr_en8) && rcnt8 >= ready_delay) ||
                         (spur && !(dram_rd_en8 || dram_wr_en8));

    always @(posedge clock) begin
        if ((dram_rd_en || dram_wr_en) && !dram_ready) rcnt <= rcnt + 1;
        else                                           rcnt <= 0;
        if ((dram_rd_en8 || dram_wr_en8) && !dram_ready8) rcnt8 <= rcnt8 + 1;
        else                                              rcnt8 <= 0;
        if (dram_wr_en && dram_ready)   dmem[dram_addr[3:0]]   <= dram_wdata;
        if (dram_wr_en8 && dram_ready8) dmem8[dram_addr8[3:0]] <= dram_wdata8;
    end

    // -----------------------------------------------------------------
    // Scoreboard counters
    // -----------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // -----------------------------------------------------------------
    // Instruction-level model of the 16-bit core
    // -----------------------------------------------------------------
    logic [7:0]  m_pc;
    logic [15:0] m_ac;
    logic [15:0] m_ar;
    logic [15:0] m_r [4];
    logic        m_z;
    logic        m_c;
    logic        m_halted;
    logic [15:0] m_dmem [16];
    logic [7:0]  fetch_q [$];
    logic [15:0] rd_addr_q [$];

    task automatic model_reset();
        m_pc = '0; m_ac = '0; m_ar = '0;
        m_z = 1'b0; m_c = 1'b0; m_halted = 1'b0;
        for (int i = 0; i < 4; i++)  m_r[i] = '0;
        for (int i = 0; i < 16; i++) m_dmem[i] = dmem[i];
        fetch_q.delete();
        rd_addr_q.delete();
    endtask

    task automatic model_exec(input logic [7:0] ins);
        logic [3:0] op;
        logic [1:0] n;
        int         s;
        op = ins[7:4];
        n  = ins[1:0];
        m_pc = m_pc + 8'd1;
        case (op)
            4'h1: begin m_ac = 16'(ins[3:0]); m_z = (m_ac == 16'd0); end
            4'h2: m_r[n] = m_ac;
            4'h3: begin m_ac = m_r[n]; m_z = (m_ac == 16'd0); end
            4'h4: begin
                s = int'(m_ac) + int'(m_r[n]);
                m_c = (s > 65535);
                m_ac = 16'(s);
                m_z = (m_ac == 16'd0);
            end
            4'h5: begin
                m_c = (m_ac < m_r[n]);
                m_ac = m_ac - m_r[n];
                m_z = (m_ac == 16'd0);
            end
            4'h6: m_r[n] = m_r[n] + 16'd1;
            4'h7: m_ar = m_r[n];
            4'h8: begin m_ac = m_dmem[m_ar[3:0]]; m_z = (m_ac == 16'd0); end
            4'h9: m_dmem[m_ar[3:0]] = m_ac;
            4'hA: if (m_z) m_pc = m_r[n][7:0];
            4'hB: m_pc = m_r[n][7:0];
            4'hF: m_halted = 1'b1;
            default: ;
        endcase
    endtask

    // Compare process: sampled on the falling edge.
    always @(negedge clock) begin
        if (reset_n === 1'b1) begin
            check("strobe_exclusive", 32'(dram_rd_en & dram_wr_en), 0);
            if (dbg_state != 3'd3) check("strobe_outside_mem", 32'(dram_rd_en | dram_wr_en), 0);
            if (dram_rd_en || dram_wr_en) begin
                check("dram_addr", dram_addr, m_ar);
                if (dram_wr_en) check("dram_wdata", dram_wdata, m_ac);
            end
            if (dbg_state == 3'd1 && iram_valid) begin
                check("fetch_after_halt", m_halted, 0);
                check("fetch_pc", iram_addr, m_pc);
                check("ac_at_fetch", dram_wdata, m_ac);
                check("z_at_fetch", zflag, m_z);
                check("c_at_fetch", cflag, m_c);
                fetch_q.push_back(iram_addr);
                model_exec(prog[m_pc]);
            end
        end
    end

    // -----------------------------------------------------------------
    // Driver tasks
    // -----------------------------------------------------------------
    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = 8'hF0;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        enable     = 1'b0;
        iram_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    // Runs with enable=1 until finish, a fetch count, or the cycle budget.
    task automatic run(input int budget, input int stop_fetches, input bit toggle,
                       output int cycles);
        cycles     = 0;
        enable     = 1'b1;
        iram_valid = 1'b1;
        while (cycles < budget) begin
            @(posedge clock);
            #1;
            cycles++;
            if (dram_rd_en) rd_addr_q.push_back(dram_addr);
            if (toggle) iram_valid = ~iram_valid;
            if (finish) break;
            if (stop_fetches != 0 && fetch_q.size() >= stop_fetches) break;
        end
        if (stop_fetches == 0) check("run_reaches_finish", finish, 1);
    endtask

    // -----------------------------------------------------------------
    // Programs
    // -----------------------------------------------------------------
    int cyc;

    initial begin
        reset_n    = 1'b0;
        enable     = 1'b0;
        iram_valid = 1'b0;
        clear_prog();

        // Reset values
        do_reset();
        check("rst_iram_addr", iram_addr, 0);
        check("rst_dram_addr", dram_addr, 0);
        check("rst_dram_wdata", dram_wdata, 0);
        check("rst_rd_en", dram_rd_en, 0);
        check("rst_wr_en", dram_wr_en, 0);
        check("rst_finish", finish, 0);
        check("rst_zflag", zflag, 0);
        check("rst_cflag", cflag, 0);
        check("rst_state", dbg_state, 0);

        // LDI 5; ST R1; LDI 3; ADD R1; HALT
        clear_prog();
        prog[0] = 8'h15; prog[1] = 8'h21; prog[2] = 8'h13; prog[3] = 8'h41; prog[4] = 8'hF0;
        do_reset();
        run(100, 0, 1'b0, cyc);
        check("p1_cycles_to_finish", cyc, 11);
        check("p1_ac", dram_wdata, 16'd8);
        check("p1_z", zflag, 0);
        check("p1_c", cflag, 0);
        check("p1_ac8", dram_wdata8, 8'd8);
        // HALT ignores enable, iram_valid and dram_ready
        enable = 1'b0;
        spur   = 1'b1;
        repeat (5) begin
            @(posedge clock);
            #1;
            iram_valid = ~iram_valid;
        end
        spur = 1'b0;
        check("halt_finish_held", finish, 1);
        check("halt_pc_held", iram_addr, 5);
        check("halt_no_strobe", 32'(dram_rd_en | dram_wr_en), 0);
        check("halt_ac_held", dram_wdata, 16'd8);

        // INC R0; SUB R0 from AC=0 -> borrow
        clear_prog();
        prog[0] = 8'h60; prog[1] = 8'h50;
        do_reset();
        run(100, 0, 1'b0, cyc);
        check("p2_ac", dram_wdata, 16'hFFFF);
        check("p2_c", cflag, 1);
        check("p2_z", zflag, 0);
        check("p2_ac8", dram_wdata8, 8'hFF);
        check("p2_c8", cflag8, 1);
        check("p2_z8", zflag8, 0);

        // ADD carry-out with zero result
        clear_prog();
        prog[0] = 8'h60; prog[1] = 8'h50; prog[2] = 8'h21; prog[3] = 8'h11; prog[4] = 8'h41;
        do_reset();
        run(100, 0, 1'b0, cyc);
        check("p3_ac", dram_wdata, 16'h0000);
        check("p3_c", cflag, 1);
        check("p3_z", zflag, 1);
        check("p3_ac8", dram_wdata8, 8'h00);
        check("p3_c8", cflag8, 1);
        check("p3_z8", zflag8, 1);

        // JZ taken: R2 = 0x10, LDI 0, JZ R2
        clear_prog();
        prog[0] = 8'h18; prog[1] = 8'h22; prog[2] = 8'h42; prog[3] = 8'h22;
        prog[4] = 8'h10; prog[5] = 8'hA2; prog[6] = 8'h1F;
        prog[8'h10] = 8'h17;
        do_reset();
        run(100, 0, 1'b0, cyc);
        check("jz_taken_fetches", fetch_q.size(), 8);
        if (fetch_q.size() > 6) check("jz_taken_target", fetch_q[6], 8'h10);
        check("jz_taken_ac", dram_wdata, 16'd7);

        // JZ not taken with zflag=0
        clear_prog();
        prog[0] = 8'h18; prog[1] = 8'h22; prog[2] = 8'h42; prog[3] = 8'h22;
        prog[4] = 8'hA2; prog[5] = 8'h13;
        do_reset();
        run(100, 0, 1'b0, cyc);
        check("jz_not_taken_fetches", fetch_q.size(), 7);
        if (fetch_q.size() > 5) check("jz_not_taken_next", fetch_q[5], 8'h05);
        check("jz_not_taken_ac", dram_wdata, 16'd3);

        // LOAD with ready held low 3 cycles, spurious ready outside MEM
        clear_prog();
        prog[0] = 8'h19; prog[1] = 8'h23; prog[2] = 8'h73; prog[3] = 8'h80;
        ready_delay = 3;
        spur        = 1'b1;
        do_reset();
        run(100, 0, 1'b0, cyc);
        spur = 1'b0;
        check("load_rd_cycles", rd_addr_q.size(), 4);
        foreach (rd_addr_q[i]) check("load_addr_stable", rd_addr_q[i], 16'd9);
        check("load_ac", dram_wdata, 16'hBEEF);
        check("load_z", zflag, 0);
        check("load_ac8", dram_wdata8, 8'hEF);

        // Reset during MEM of a STORE
        clear_prog();
        prog[0] = 8'h16; prog[1] = 8'h20; prog[2] = 8'h70; prog[3] = 8'h90;
        ready_delay = 100;
        do_reset();
        enable     = 1'b1;
        iram_valid = 1'b1;
        cyc = 0;
        while (!dram_wr_en && cyc < 50) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        check("store_strobe_seen", dram_wr_en, 1);
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        check("store_strobe_held", dram_wr_en, 1);
        check("store_addr", dram_addr, 16'd6);
        check("store_data", dram_wdata, 16'd6);
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        check("mid_rst_wr_en", dram_wr_en, 0);
        check("mid_rst_wr_en8", dram_wr_en8, 0);
        check("mid_rst_state", dbg_state, 0);
        check("mid_rst_pc", iram_addr, 0);
        check("mid_rst_addr", dram_addr, 0);
        check("mid_rst_wdata", dram_wdata, 0);
        check("mid_rst_z", zflag, 0);
        check("mid_rst_c", cflag, 0);
        check("mid_rst_finish", finish, 0);
        reset_n = 1'b1;
        enable  = 1'b0;
        model_reset();
        repeat (4) begin
            @(posedge clock);
            #1;
        end
        check("post_rst_idle", dbg_state, 0);
        check("post_rst_pc", iram_addr, 0);
        check("post_rst_no_strobe", 32'(dram_rd_en | dram_wr_en), 0);
        check("abandoned_store", dmem[6], 16'h1234);

        // From IDLE: STORE then LOAD back, with iram_valid toggling
        clear_prog();
        prog[0] = 8'h16; prog[1] = 8'h20; prog[2] = 8'h70; prog[3] = 8'h1C;
        prog[4] = 8'h90; prog[5] = 8'h11; prog[6] = 8'h80;
        ready_delay = 1;
        run(400, 0, 1'b1, cyc);
        check("st_ld_ac", dram_wdata, 16'h000C);
        check("st_ld_z", zflag, 0);
        check("st_ld_mem", dmem[6], 16'h000C);
        check("st_ld_ac8", dram_wdata8, 8'h0C);

        // enable dropped after JMP: IDLE with PC kept, then resume
        clear_prog();
        prog[0] = 8'h14; prog[1] = 8'h21; prog[2] = 8'hB1; prog[3] = 8'h1F;
        prog[4] = 8'h13; prog[5] = 8'hC0;
        ready_delay = 0;
        do_reset();
        run(100, 3, 1'b0, cyc);
        enable = 1'b0;
        repeat (4) begin
            @(posedge clock);
            #1;
        end
        check("pause_idle", dbg_state, 0);
        check("pause_pc", iram_addr, 4);
        check("pause_finish", finish, 0);
        run(100, 0, 1'b0, cyc);
        check("resume_fetches", fetch_q.size(), 6);
        if (fetch_q.size() > 3) check("resume_pc", fetch_q[3], 8'h04);
        check("resume_ac", dram_wdata, 16'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
